wave_tone_gen: RTL and testbench

//  Two-channel parametrised tone source for the Audio_Controller sample path.
//  Per channel: phase-accumulator oscillator with selectable square/saw/triangle/mute shape and amplitude scaling.

---
 rtl/wave_tone_gen.sv | 129 ++++++++++++
 tb/tb_wave_tone_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_tone_gen.sv
// Two-channel phase-accumulator tone source (square/saw/triangle/mute) feeding the
// audio controller's sample FIFO through its audio_out_allowed / write_audio_out handshake.
module wave_tone_gen #(
  parameter int PHASE_W  = 24,
  parameter int WAVE_W   = 16,
  parameter int AMP_W    = 8,
  parameter int SAMPLE_W = 32
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                phase_clr,
  input  logic [PHASE_W-1:0]  inc_l,
  input  logic [PHASE_W-1:0]  inc_r,
  input  logic [1:0]          mode_l,
  input  logic [1:0]          mode_r,
  input  logic [AMP_W-1:0]    amp_l,
  input  logic [AMP_W-1:0]    amp_r,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic [15:0]         sample_count
);

  localparam int M = PHASE_W - 1;
  localparam logic signed [WAVE_W-1:0] SQ_POS = {1'b0, {(WAVE_W-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, C1, C2, READY, WRITE} state_t;

  state_t state, state_next;

  logic [PHASE_W-1:0]       phase_l, phase_r;
  logic [PHASE_W-1:0]       inc_l_reg, inc_r_reg;
  logic [AMP_W-1:0]         amp_l_reg, amp_r_reg;
  logic signed [WAVE_W-1:0] wave_l_reg, wave_r_reg;

  function automatic logic signed [WAVE_W-1:0] raw_wave(input logic [PHASE_W-1:0] p,
                                                        input logic [1:0] mode);
    logic [WAVE_W-1:0]        q;
    logic [WAVE_W-1:0]        u;
    logic signed [WAVE_W-1:0] w;
    q = p[M-1 -: WAVE_W];
    u = p[M] ? ~q : q;
    case (mode)
      2'b00:   w = p[M] ? -SQ_POS : SQ_POS;
      2'b01:   w = {~p[M], p[M-1 -: WAVE_W-1]};
      2'b10:   w = {~u[WAVE_W-1], u[WAVE_W-2:0]};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Bit-slicing the full product at AMP_W is the arithmetic right shift, then truncation.
  function automatic logic signed [WAVE_W-1:0] scale(input logic signed [WAVE_W-1:0] w,
                                                     input logic [AMP_W-1:0] amp);
    logic signed [WAVE_W+AMP_W:0] prod;
    prod = w * $signed({1'b0, amp});
    return prod[AMP_W +: WAVE_W];
  endfunction

  function automatic logic [SAMPLE_W-1:0] justify(input logic signed [WAVE_W-1:0] s);
    logic [SAMPLE_W-1:0] r;
    r = '0;
    r[SAMPLE_W-1 -: WAVE_W] = s;
    return r;
  endfunction

  // A clear in C1/C2/READY throws away the sample in flight and restarts at C1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = C1;
      C1:      if (!enable) state_next = IDLE;
               else if (phase_clr) state_next = C1;
               else state_next = C2;
      C2:      if (!enable) state_next = IDLE;
               else if (phase_clr) state_next = C1;
               else state_next = READY;
      READY:   if (!enable) state_next = IDLE;
               else if (phase_clr) state_next = C1;
               else if (audio_out_allowed) state_next = WRITE;
      WRITE:   state_next = enable ? C1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign write_audio_out = (state == WRITE);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      phase_l                 <= '0;
      phase_r                 <= '0;
      inc_l_reg               <= '0;
      inc_r_reg               <= '0;
      amp_l_reg               <= '0;
      amp_r_reg               <= '0;
      wave_l_reg              <= '0;
      wave_r_reg              <= '0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      sample_count            <= '0;
    end else begin
      state <= state_next;
      if (state == C1) begin
        inc_l_reg  <= inc_l;
        inc_r_reg  <= inc_r;
        amp_l_reg  <= amp_l;
        amp_r_reg  <= amp_r;
        wave_l_reg <= raw_wave(phase_l, mode_l);
        wave_r_reg <= raw_wave(phase_r, mode_r);
      end
      if (state == C2 && state_next == READY) begin
        left_channel_audio_out  <= justify(scale(wave_l_reg, amp_l_reg));
        right_channel_audio_out <= justify(scale(wave_r_reg, amp_r_reg));
      end
      if (phase_clr) begin
        phase_l <= '0;
        phase_r <= '0;
      end else if (state == WRITE) begin
        phase_l <= phase_l + inc_l_reg;
        phase_r <= phase_r + inc_r_reg;
      end
      if (state == WRITE) sample_count <= sample_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wave_tone_gen.sv
// Randomised bench for wave_tone_gen: every written sample is compared with an
// arithmetic model of phase, waveform shape and amplitude scaling.
module tb_wave_tone_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        phase_clr = 1'b0;
  logic [23:0] inc_l = '0, inc_r = '0;
  logic [1:0]  mode_l = '0, mode_r = '0;
  logic [7:0]  amp_l = '0, amp_r = '0;
  logic        audio_out_allowed = 1'b0;
  logic        write_audio_out;
  logic [31:0] left_out, right_out;
  logic [15:0] sample_count;

  int n_checks = 0;
  int n_errors = 0;

  // model state: configuration for the next sample, phases and write count
  int m_inc_l, m_inc_r, m_mode_l, m_mode_r, m_amp_l, m_amp_r;
  int m_phase_l = 0, m_phase_r = 0, m_count = 0;

  always #5 clk = ~clk;

  wave_tone_gen dut (
    .CLOCK_50                (clk),
    .reset_n                 (reset_n),
    .enable                  (enable),
    .phase_clr               (phase_clr),
    .inc_l                   (inc_l),
    .inc_r                   (inc_r),
    .mode_l                  (mode_l),
    .mode_r                  (mode_r),
    .amp_l                   (amp_l),
    .amp_r                   (amp_r),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .sample_count            (sample_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waveform from phase as a fraction of the cycle, scaled by amp/256 with floor rounding.
  function automatic logic [31:0] exp_sample(input int phase, input int mode, input int amp);
    longint w, s, t;
    logic [31:0] r;
    case (mode)
      0: w = (phase < 8388608) ? 32767 : -32767;
      1: w = longint'(phase / 256) - 32768;
      2: begin
        t = longint'(phase / 128);
        w = (t < 65536) ? t - 32768 : (131071 - t) - 32768;
      end
      default: w = 0;
    endcase
    s = (w * amp) >>> 8;
    r = {s[15:0], 16'h0000};
    return r;
  endfunction

  task automatic set_cfg(input int il, input int ml, input int al,
                         input int ir, input int mr, input int ar);
    inc_l = il[23:0]; mode_l = ml[1:0]; amp_l = al[7:0];
    inc_r = ir[23:0]; mode_r = mr[1:0]; amp_r = ar[7:0];
    m_inc_l = il; m_mode_l = ml; m_amp_l = al;
    m_inc_r = ir; m_mode_r = mr; m_amp_r = ar;
  endtask

  task automatic set_random_cfg();
    set_cfg(int'($urandom & 32'hFFFFFF), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom & 32'hFFFFFF), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
  endtask

  task automatic wait_write(input int budget, input bit rand_allow, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (cycles < budget && !got) begin
      @(negedge clk);
      cycles++;
      if (write_audio_out) got = 1'b1;
      else if (rand_allow) audio_out_allowed = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Called at the negedge where the write strobe is high.
  task automatic check_sample(input string tag);
    logic [31:0] el, er;
    el = exp_sample(m_phase_l, m_mode_l, m_amp_l);
    er = exp_sample(m_phase_r, m_mode_r, m_amp_r);
    $display("%s sample %0d: L=%h (exp %h) R=%h (exp %h)", tag, m_count, left_out, el, right_out, er);
    check({tag, "_left"}, left_out, el);
    check({tag, "_right"}, right_out, er);
    check({tag, "_count"}, 32'(sample_count), 32'(m_count));
    m_phase_l = (m_phase_l + m_inc_l) % 16777216;
    m_phase_r = (m_phase_r + m_inc_r) % 16777216;
    m_count   = (m_count + 1) % 65536;
  endtask

  task automatic expect_sample(input string tag, input bit rand_allow, output int cycles);
    bit got;
    wait_write(400, rand_allow, cycles, got);
    check({tag, "_strobe"}, 32'(got), 32'd1);
    if (got) check_sample(tag);
  endtask

  initial begin
    int cyc, strobes;
    logic [31:0] hold_l, hold_r, hold_c;

    repeat (3) @(negedge clk);
    check("rst_write", 32'(write_audio_out), 32'd0);
    check("rst_left", left_out, 32'd0);
    check("rst_right", right_out, 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);

    reset_n = 1'b1;
    strobes = 0;
    repeat (100) begin
      @(negedge clk);
      if (write_audio_out) strobes++;
    end
    check("idle_no_write", 32'(strobes), 32'd0);

    // square on left, saw then triangle on right
    set_cfg(32'h400000, 0, 255, 32'h400000, 1, 128);
    audio_out_allowed = 1'b1;
    enable = 1'b1;
    expect_sample("square", 1'b0, cyc);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) set_cfg(32'h400000, 0, 255, 32'h400000, 2, 128);
      expect_sample("square", 1'b0, cyc);
      check("interval", 32'(cyc), 32'd4);
    end

    for (int i = 0; i < 40; i++) begin
      set_random_cfg();
      expect_sample("random", 1'b1, cyc);
    end
    audio_out_allowed = 1'b1;

    // backpressure: stall in READY for 50 cycles
    set_random_cfg();
    audio_out_allowed = 1'b0;
    strobes = 0;
    hold_l = '0; hold_r = '0; hold_c = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (write_audio_out) strobes++;
      if (i == 9) begin
        hold_l = left_out; hold_r = right_out; hold_c = 32'(sample_count);
        check("bp_left_ready", left_out, exp_sample(m_phase_l, m_mode_l, m_amp_l));
      end
    end
    check("bp_no_strobe", 32'(strobes), 32'd0);
    check("bp_left_hold", left_out, hold_l);
    check("bp_right_hold", right_out, hold_r);
    check("bp_count_hold", 32'(sample_count), hold_c);
    audio_out_allowed = 1'b1;
    @(negedge clk);
    check("bp_release_strobe", 32'(write_audio_out), 32'd1);
    if (write_audio_out) check_sample("bp");

    // config change while in C2 must not affect the sample in flight
    set_cfg(32'h123456, 0, 200, 32'h0ABCDE, 2, 150);
    @(negedge clk);
    @(negedge clk);
    mode_r = 2'b11;
    expect_sample("cfgchg", 1'b0, cyc);
    m_mode_r = 3;
    expect_sample("mute", 1'b0, cyc);
    check("mute_right_zero", right_out, 32'd0);

    // enable dropped during WRITE: write completes, then idle with outputs held
    enable = 1'b0;
    hold_l = left_out; hold_r = right_out;
    strobes = 0;
    repeat (20) begin
      @(negedge clk);
      if (write_audio_out) strobes++;
    end
    check("dis_no_strobe", 32'(strobes), 32'd0);
    check("dis_left_hold", left_out, hold_l);
    check("dis_right_hold", right_out, hold_r);
    enable = 1'b1;
    expect_sample("reenable", 1'b0, cyc);

    // phase_clr while waiting in READY
    audio_out_allowed = 1'b0;
    repeat (5) @(negedge clk);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    m_phase_l = 0;
    m_phase_r = 0;
    audio_out_allowed = 1'b1;
    expect_sample("phclr", 1'b0, cyc);
    expect_sample("phclr_next", 1'b0, cyc);

    // reset pulse in C2
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_write", 32'(write_audio_out), 32'd0);
    check("midrst_left", left_out, 32'd0);
    check("midrst_right", right_out, 32'd0);
    check("midrst_count", 32'(sample_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_phase_l = 0;
    m_phase_r = 0;
    m_count = 0;
    expect_sample("after_rst", 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      set_random_cfg();
      expect_sample("tail", 1'b0, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
